// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: resolves BEQ-style branches and forwards non-branch
// instructions to the memory stage through a 2-entry skid buffer.
module ex_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_alu_out,
  input  logic          in_zero,
  input  logic [DW-1:0] in_store_data,
  input  logic [RW-1:0] in_rd,
  input  logic          in_reg_write,
  input  logic          in_mem_read,
  input  logic          in_mem_write,
  input  logic          in_branch,
  input  logic [DW-1:0] in_branch_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_addr,
  output logic [DW-1:0] out_store_data,
  output logic [RW-1:0] out_rd,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          redirect_valid,
  output logic [DW-1:0] redirect_pc,
  output logic [15:0]   taken_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [DW-1:0] store_data;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } entry_t;

  state_t state, state_n;
  entry_t head_q, skid_q, in_entry;
  logic   accept, push, pop, taken;
  logic   ld_head_in, ld_head_skid, ld_skid;

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);

  assign accept = in_valid && in_ready;
  assign push   = accept && !in_branch;
  assign pop    = out_valid && out_ready;
  assign taken  = accept && in_branch && in_zero;

  assign in_entry = '{addr:       in_alu_out,
                      store_data: in_store_data,
                      rd:         in_rd,
                      reg_write:  in_reg_write,
                      mem_read:   in_mem_read,
                      mem_write:  in_mem_write};

  always_comb begin
    state_n      = state;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_n    = ONE;
          ld_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          ld_head_in = 1'b1;
        end else if (push) begin
          state_n = TWO;
          ld_skid = 1'b1;
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_n      = ONE;
          ld_head_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      if (ld_head_in) begin
        head_q <= in_entry;
      end else if (ld_head_skid) begin
        head_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      taken_cnt      <= '0;
    end else begin
      redirect_valid <= taken;
      if (taken) begin
        redirect_pc <= in_branch_target;
        taken_cnt   <= taken_cnt + 16'd1;
      end
    end
  end

  assign out_addr       = head_q.addr;
  assign out_store_data = head_q.store_data;
  assign out_rd         = head_q.rd;
  assign out_reg_write  = head_q.reg_write;
  assign out_mem_read   = head_q.mem_read;
  assign out_mem_write  = head_q.mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_alu_out;
  logic          in_zero;
  logic [DW-1:0] in_store_data;
  logic [RW-1:0] in_rd;
  logic          in_reg_write;
  logic          in_mem_read;
  logic          in_mem_write;
  logic          in_branch;
  logic [DW-1:0] in_branch_target;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_addr;
  logic [DW-1:0] out_store_data;
  logic [RW-1:0] out_rd;
  logic          out_reg_write;
  logic          out_mem_read;
  logic          out_mem_write;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic [15:0]   taken_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_alu_out       (in_alu_out),
    .in_zero          (in_zero),
    .in_store_data    (in_store_data),
    .in_rd            (in_rd),
    .in_reg_write     (in_reg_write),
    .in_mem_read      (in_mem_read),
    .in_mem_write     (in_mem_write),
    .in_branch        (in_branch),
    .in_branch_target (in_branch_target),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr),
    .out_store_data   (out_store_data),
    .out_rd           (out_rd),
    .out_reg_write    (out_reg_write),
    .out_mem_read     (out_mem_read),
    .out_mem_write    (out_mem_write),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .taken_cnt        (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid         = 1'b0;
    in_alu_out       = '0;
    in_zero          = 1'b0;
    in_store_data    = '0;
    in_rd            = '0;
    in_reg_write     = 1'b0;
    in_mem_read      = 1'b0;
    in_mem_write     = 1'b0;
    in_branch        = 1'b0;
    in_branch_target = '0;
  endtask

  task automatic drive_push(input logic [DW-1:0] val, input logic [RW-1:0] rd);
    idle_inputs();
    in_valid   = 1'b1;
    in_alu_out = val;
    in_rd      = rd;
    in_reg_write = 1'b1;
  endtask

  task automatic drive_branch(input logic zero, input logic [DW-1:0] tgt);
    idle_inputs();
    in_valid         = 1'b1;
    in_branch        = 1'b1;
    in_zero          = zero;
    in_branch_target = tgt;
  endtask

  initial begin
    int unsigned pushed;
    int unsigned popped;
    int unsigned cyc;
    logic [DW-1:0] exp_val;

    idle_inputs();
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_redirect", redirect_valid, 0);
    check("rst_taken_cnt", taken_cnt, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    reset = 1'b0;
    tick();

    // Single push, drained immediately
    drive_push(16'h1234, 3'd3);
    tick();
    idle_inputs();
    check("p1_valid", out_valid, 1);
    check("p1_addr", out_addr, 16'h1234);
    check("p1_rd", out_rd, 3);
    check("p1_reg_write", out_reg_write, 1);
    tick();
    check("p1_drained", out_valid, 0);

    // Fill both entries with the consumer stalled
    out_ready = 1'b0;
    drive_push(16'h0001, 3'd1);
    tick();
    check("fill1_in_ready", in_ready, 1);
    drive_push(16'h0002, 3'd2);
    in_store_data = 16'hBEEF;
    in_mem_read   = 1'b1;
    in_mem_write  = 1'b1;
    tick();
    idle_inputs();
    check("fill2_in_ready", in_ready, 0);
    check("fill2_head", out_addr, 16'h0001);
    tick();
    check("stall_valid", out_valid, 1);
    check("stall_head", out_addr, 16'h0001);
    check("stall_rd", out_rd, 1);
    out_ready = 1'b1;
    tick();
    check("drain_second", out_addr, 16'h0002);
    check("drain_sd", out_store_data, 16'hBEEF);
    check("drain_mr", out_mem_read, 1);
    check("drain_mw", out_mem_write, 1);
    check("drain_in_ready", in_ready, 1);
    tick();
    check("drain_empty", out_valid, 0);

    // Taken branch, carrying store bits that must not enqueue
    drive_branch(1'b1, 16'h0040);
    in_mem_write = 1'b1;
    tick();
    idle_inputs();
    check("br_redirect", redirect_valid, 1);
    check("br_pc", redirect_pc, 16'h0040);
    check("br_cnt", taken_cnt, 1);
    check("br_no_enq", out_valid, 0);
    tick();
    check("br_pulse_end", redirect_valid, 0);
    drive_branch(1'b0, 16'h0040);
    tick();
    idle_inputs();
    check("nt_redirect", redirect_valid, 0);
    check("nt_cnt", taken_cnt, 1);
    check("nt_no_enq", out_valid, 0);

    // Branch accepted while the single head entry pops
    drive_push(16'h0077, 3'd7);
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    drive_branch(1'b1, 16'h0100);
    tick();
    idle_inputs();
    check("brpop_empty", out_valid, 0);
    check("brpop_redirect", redirect_valid, 1);
    check("brpop_pc", redirect_pc, 16'h0100);
    check("brpop_cnt", taken_cnt, 2);

    // Streaming 8 pushes with out_ready toggling 1,0,1,0
    pushed = 0;
    popped = 0;
    cyc    = 0;
    while (popped < 8 && cyc < 60) begin
      out_ready = (cyc % 2 == 0);
      if (pushed < 8) begin
        drive_push(16'h0010 + 16'(pushed), 3'(pushed));
      end else begin
        idle_inputs();
      end
      if (out_valid && out_ready) begin
        exp_val = 16'h0010 + 16'(popped);
        check("stream_data", out_addr, exp_val);
        popped++;
      end
      if (in_valid && in_ready) pushed++;
      tick();
      cyc++;
    end
    idle_inputs();
    check("stream_count", popped, 8);
    check("stream_no_dup", out_valid, 0);

    // Asynchronous reset while both entries are full
    out_ready = 1'b0;
    drive_push(16'hAAAA, 3'd5);
    tick();
    drive_push(16'hBBBB, 3'd6);
    tick();
    idle_inputs();
    check("two_in_ready", in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_cnt", taken_cnt, 0);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("arst_discard", out_valid, 0);
    drive_push(16'h5555, 3'd4);
    tick();
    idle_inputs();
    check("arst_fresh", out_addr, 16'h5555);

    // Counter wrap after 65535 taken branches
    drive_branch(1'b1, 16'h0200);
    for (int i = 0; i < 65535; i++) tick();
    check("wrap_ffff", taken_cnt, 16'hFFFF);
    tick();
    idle_inputs();
    check("wrap_zero", taken_cnt, 16'h0000);
    check("wrap_redirect", redirect_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
